// File: rtl/alu_pkg.sv
// alu_pkg: constants shared between the issue stage and the ALU.
//   ALU_* : 3-bit alu_control encodings (also decoded by the ALU itself)
//   OPC_* : RV32I major opcodes handled by the issue stage
//   F3_* / F7_* : funct3 / funct7 field values
//   decode(): maps an instruction word to {legal, alu_op, use_rs2}
package alu_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef struct packed {
    logic       legal;
    logic [2:0] alu_op;
    logic       use_rs2;   // R-type: b comes from rs2 and rs2 is hazard-checked
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    d  = '0;
    f3 = instr[14:12];
    f7 = instr[31:25];   // for OP-IMM this is imm[11:5]
    case (instr[6:0])
      OPC_OP: begin
        d.legal   = 1'b1;
        d.use_rs2 = 1'b1;
        case (f3)
          F3_ADD_SUB: begin
            if (f7 == F7_BASE)     d.alu_op = ALU_ADD;
            else if (f7 == F7_SUB) d.alu_op = ALU_SUB;
            else                   d.legal  = 1'b0;
          end
          F3_AND:  d.alu_op = ALU_AND;
          F3_OR:   d.alu_op = ALU_OR;
          F3_XOR:  d.alu_op = ALU_XOR;
          F3_SLL: begin
            if (f7 == F7_BASE) d.alu_op = ALU_SLL;
            else               d.legal  = 1'b0;
          end
          default: d.legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        d.legal = 1'b1;
        case (f3)
          F3_ADD_SUB: d.alu_op = ALU_ADD;
          F3_AND:     d.alu_op = ALU_AND;
          F3_OR:      d.alu_op = ALU_OR;
          F3_XOR:     d.alu_op = ALU_XOR;
          F3_SLL: begin
            if (f7 == F7_BASE) d.alu_op = ALU_SLL;
            else               d.legal  = 1'b0;
          end
          default: d.legal = 1'b0;
        endcase
      end
      default: ;
    endcase
    // Illegal ops issue as a clean all-zero bundle.
    if (!d.legal) d = '0;
    return d;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: integer register file, 2 combinational read ports, 1 write port.
//   clk, rst        : clock, async active-high reset (clears every register)
//   ra1/ra2 -> rd1/rd2 : read ports; x0 reads 0; a same-cycle write to the
//                    addressed register is forwarded (write-through bypass)
//   we, wa, wd      : write port, committed on the rising edge; writes to x0 dropped
module regfile_2r1w #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [NUM_REGS-1:0][XLEN-1:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   mem     <= '0;
    else if (we && wa != '0)   mem[wa] <= wd;
  end

  assign rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : (we && wa == ra2) ? wd : mem[ra2];

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode/issue stage feeding the combinational ALU.
//   clk, rst           : clock, async active-high reset
//   in_valid/in_ready  : upstream handshake; instr must be held while stalled
//   instr              : RV32I instruction word
//   out_valid/out_ready: downstream handshake on the single output register
//   a, b, alu_control, rd, illegal : issued operand bundle
//   wb_en, wb_rd, wb_data : ALU result writeback (regfile + scoreboard clear)
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [2:0]      alu_control,
  output logic [4:0]      rd,
  output logic            illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [4:0]          rs1, rs2, rd_fld;
  dec_t                dec;
  logic [XLEN-1:0]     rs1_val, rs2_val, imm_sx;
  logic [NUM_REGS-1:0] pending, pend_nxt;
  logic                busy_rs1, busy_rs2, busy_rd, hazard, accept;

  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd_fld = instr[11:7];
  assign dec    = decode(instr);
  assign imm_sx = {{(XLEN-12){instr[31]}}, instr[31:20]};

  regfile_2r1w #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .AW(5)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rs1_val),
    .rd2 (rs2_val),
    .we  (wb_en),
    .wa  (wb_rd),
    .wd  (wb_data)
  );

  // A pending register stops blocking in the very cycle its writeback arrives,
  // since the regfile bypass already delivers the new value.
  assign busy_rs1 = pending[rs1]    && !(wb_en && wb_rd == rs1);
  assign busy_rs2 = pending[rs2]    && !(wb_en && wb_rd == rs2);
  assign busy_rd  = pending[rd_fld] && !(wb_en && wb_rd == rd_fld);

  // Illegal ops never touch the register file, so they skip the hazard check.
  assign hazard   = dec.legal && (busy_rs1 || (dec.use_rs2 && busy_rs2) || busy_rd);
  assign in_ready = (!out_valid || out_ready) && !hazard && !rst;
  assign accept   = in_valid && in_ready;

  // Clear first, then set, so a same-register set/clear leaves the bit set.
  always_comb begin
    pend_nxt = pending;
    if (wb_en) pend_nxt[wb_rd] = 1'b0;
    if (accept && dec.legal && rd_fld != '0) pend_nxt[rd_fld] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pend_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      a           <= '0;
      b           <= '0;
      alu_control <= ALU_ADD;
      rd          <= '0;
      illegal     <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      illegal     <= !dec.legal;
      alu_control <= dec.alu_op;
      if (dec.legal) begin
        a  <= rs1_val;
        b  <= dec.use_rs2 ? rs2_val : imm_sx;
        rd <= rd_fld;
      end else begin
        a  <= '0;
        b  <= '0;
        rd <= '0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, illegal, wb_en;
  logic [31:0] instr, a, b, wb_data;
  logic [2:0]  alu_control;
  logic [4:0]  rd, wb_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .alu_control(alu_control), .rd(rd), .illegal(illegal),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rdd);
    return {f7, r2, r1, f3, rdd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rdd);
    return {imm, r1, f3, rdd, 7'b0010011};
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input logic [31:0] ins, input string nm);
    int n;
    n = 0;
    in_valid = 1'b1;
    instr    = ins;
    #1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s: in_ready timeout got 0 expected 1", nm);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    string       nm;
    logic [31:0] ins, ea, eb;
    logic [2:0]  ectl;
    logic [4:0]  erd;
    logic        eill;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input string nm, input logic [31:0] ins, input logic [31:0] ea,
                      input logic [31:0] eb, input logic [2:0] ectl, input logic [4:0] erd,
                      input logic eill);
    vec_t v;
    v.nm = nm; v.ins = ins; v.ea = ea; v.eb = eb; v.ectl = ectl; v.erd = erd; v.eill = eill;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_reg [32];
  bit          m_pend[32];
  bit          m_ov, m_ill;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_ctl;
  logic [4:0]  m_rd;

  // ALU op number (0 ADD .. 5 SLL) for a supported instruction, -1 otherwise.
  function automatic int ref_op(input logic [31:0] w);
    bit r, i;
    r = (w[6:0] == 7'h33);
    i = (w[6:0] == 7'h13);
    if (!r && !i) return -1;
    case (w[14:12])
      3'd0: begin
        if (i || w[31:25] == 7'h00) return 0;
        if (w[31:25] == 7'h20) return 1;
        return -1;
      end
      3'd7: return 2;
      3'd6: return 3;
      3'd4: return 4;
      3'd1: return (w[31:25] == 7'h00) ? 5 : -1;
      default: return -1;
    endcase
  endfunction

  function automatic bit m_busy(input logic [4:0] r);
    return m_pend[r] && !(wb_en && wb_rd == r);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wb_en && wb_rd == r) return wb_data;
    return m_reg[r];
  endfunction

  function automatic logic [31:0] rnd_instr();
    int          k, k2;
    logic [4:0]  r1, r2, rdd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    k   = $urandom_range(0, 9);
    r1  = 5'($urandom_range(0, 7));
    r2  = 5'($urandom_range(0, 7));
    rdd = 5'($urandom_range(0, 7));
    f3  = 3'($urandom);
    if (k < 5) begin
      k2 = $urandom_range(0, 5);
      f7 = (k2 < 4) ? 7'h00 : (k2 == 4) ? 7'h20 : 7'($urandom);
      return enc_r(f7, r2, r1, f3, rdd);
    end else if (k < 9) begin
      imm = 12'($urandom);
      if (f3 == 3'd1 && $urandom_range(0, 1) == 1) imm[11:5] = 7'h00;
      return enc_i(imm, r1, f3, rdd);
    end
    return $urandom;
  endfunction

  initial begin
    bit   stall_prev, er, hz, acc, rtype;
    int   op, n;
    logic [4:0] cand[$];

    rst = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset a", a, 0);
    chk("reset b", b, 0);
    chk("reset alu_control", alu_control, 0);
    chk("reset rd", rd, 0);
    chk("reset illegal", illegal, 0);
    chk("reset in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // ADDI x1,x0,10
    issue(32'h00A00093, "addi x1");
    chk("addi out_valid", out_valid, 1);
    chk("addi a", a, 0);
    chk("addi b", b, 10);
    chk("addi ctl", alu_control, 0);
    chk("addi rd", rd, 1);
    wb(1, 32'd10);
    issue(enc_r(7'h00, 5'd0, 5'd1, 3'd0, 5'd5), "read x1");
    chk("x1 after wb", a, 10);
    wb(5, 0);

    // SUB x3,x1,x2
    wb(1, 32'd20);
    wb(2, 32'd8);
    issue(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), "sub");
    chk("sub a", a, 20);
    chk("sub b", b, 8);
    chk("sub ctl", alu_control, 1);
    chk("sub rd", rd, 3);
    chk("sub alu result", a - b, 12);
    wb(3, 32'd12);

    // RAW hazard resolved by same-cycle writeback
    issue(enc_i(12'd5, 5'd0, 3'd0, 5'd1), "addi x1,5");
    in_valid = 1'b1;
    instr    = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
    for (int i = 0; i < 2; i++) begin
      #1; chk("hazard in_ready low", in_ready, 0);
      @(posedge clk); #1;
    end
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
    #1; chk("hazard in_ready on wb", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; wb_en = 1'b0;
    chk("bypass a", a, 5);
    chk("bypass b", b, 5);
    chk("bypass rd", rd, 2);
    wb(2, 0);

    // Backpressure then back-to-back drain
    issue(enc_i(12'd4, 5'd0, 3'd0, 5'd4), "addi x4");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = enc_i(12'd5, 5'd0, 3'd0, 5'd5);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp out_valid", out_valid, 1);
      chk("bp a", a, 0);
      chk("bp b", b, 4);
      chk("bp ctl", alu_control, 0);
      chk("bp rd", rd, 4);
      chk("bp in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1; chk("drain in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("b2b first valid", out_valid, 1);
    chk("b2b first b", b, 5);
    chk("b2b first rd", rd, 5);
    instr = enc_i(12'd6, 5'd0, 3'd0, 5'd6);
    #1; chk("b2b in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b second valid", out_valid, 1);
    chk("b2b second b", b, 6);
    chk("b2b second rd", rd, 6);
    wb(4, 0); wb(5, 0); wb(6, 0);

    // Illegal ops and x0
    issue(32'h00000063, "beq");
    chk("beq illegal", illegal, 1);
    chk("beq rd", rd, 0);
    chk("beq ctl", alu_control, 0);
    issue(32'h000000E3, "illegal rd1");
    chk("illegal rd field dropped", rd, 0);
    chk("illegal a", a, 0);
    in_valid = 1'b1;
    instr    = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd1);
    #1; chk("no pending from illegal", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wb(1, 32'd5);
    issue(enc_i(12'd7, 5'd0, 3'd0, 5'd0), "addi x0");
    chk("addi x0 rd", rd, 0);
    chk("addi x0 b", b, 7);
    chk("addi x0 illegal", illegal, 0);
    wb(0, 32'hDEAD_BEEF);
    issue(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd7), "read x0");
    chk("x0 reads 0", a, 0);
    chk("x0 reads 0 b", b, 0);
    wb(7, 0);

    // Reset while an op is held and x1 is pending
    out_ready = 1'b0;
    issue(enc_i(12'd9, 5'd0, 3'd0, 5'd1), "addi x1,9");
    chk("pre-reset out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("reset drops out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    instr = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
    #1; chk("post-reset no stall", in_ready, 1);
    issue(instr, "post-reset add");
    chk("post-reset x1 a", a, 0);
    chk("post-reset x1 b", b, 0);
    wb(2, 0);

    // Table-driven decode coverage
    wb(1, 32'd20); wb(2, 32'd8); wb(5, 32'hFFFF_FFFD); wb(6, 32'h0000_00F0);
    addv("t add",  enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 20, 8, 0, 3, 0);
    addv("t sub",  enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 20, 8, 1, 3, 0);
    addv("t and",  enc_r(7'h00, 5'd6, 5'd5, 3'd7, 5'd4), 32'hFFFF_FFFD, 32'hF0, 2, 4, 0);
    addv("t or",   enc_r(7'h00, 5'd6, 5'd1, 3'd6, 5'd7), 20, 32'hF0, 3, 7, 0);
    addv("t xor",  enc_r(7'h00, 5'd5, 5'd2, 3'd4, 5'd7), 8, 32'hFFFF_FFFD, 4, 7, 0);
    addv("t sll",  enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd8), 20, 8, 5, 8, 0);
    addv("t addi", enc_i(12'hFFF, 5'd1, 3'd0, 5'd9), 20, 32'hFFFF_FFFF, 0, 9, 0);
    addv("t andi", enc_i(12'h7FF, 5'd5, 3'd7, 5'd9), 32'hFFFF_FFFD, 32'h7FF, 2, 9, 0);
    addv("t ori",  enc_i(12'h800, 5'd0, 3'd6, 5'd10), 0, 32'hFFFF_F800, 3, 10, 0);
    addv("t xori", enc_i(12'h005, 5'd2, 3'd4, 5'd10), 8, 5, 4, 10, 0);
    addv("t slli", enc_i(12'h003, 5'd1, 3'd1, 5'd11), 20, 3, 5, 11, 0);
    addv("t srai", enc_i(12'h403, 5'd1, 3'd1, 5'd11), 0, 0, 0, 0, 1);
    addv("t srl",  enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd3), 0, 0, 0, 0, 1);
    addv("t f7sll", enc_r(7'h20, 5'd2, 5'd1, 3'd1, 5'd3), 0, 0, 0, 0, 1);
    addv("t slti", enc_i(12'h005, 5'd1, 3'd2, 5'd3), 0, 0, 0, 0, 1);
    addv("t lui",  32'h1234_5037, 0, 0, 0, 0, 1);
    addv("t mul",  enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3), 0, 0, 0, 0, 1);
    foreach (tbl[i]) begin
      issue(tbl[i].ins, tbl[i].nm);
      chk({tbl[i].nm, " valid"}, out_valid, 1);
      chk({tbl[i].nm, " a"}, a, tbl[i].ea);
      chk({tbl[i].nm, " b"}, b, tbl[i].eb);
      chk({tbl[i].nm, " ctl"}, alu_control, tbl[i].ectl);
      chk({tbl[i].nm, " rd"}, rd, tbl[i].erd);
      chk({tbl[i].nm, " illegal"}, illegal, tbl[i].eill);
      if (tbl[i].erd != 0) wb(tbl[i].erd, 0);
    end

    // Randomized run against the reference model
    do_reset();
    for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_pend[i] = 0; end
    m_ov = 0; m_ill = 0; m_a = '0; m_b = '0; m_ctl = '0; m_rd = '0;
    stall_prev = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!stall_prev) begin
        in_valid = ($urandom_range(0, 2) != 0);
        instr    = rnd_instr();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en     = ($urandom_range(0, 2) == 0);
      cand.delete();
      for (int r = 1; r < 8; r++) if (m_pend[r]) cand.push_back(5'(r));
      if (cand.size() > 0 && $urandom_range(0, 3) != 0)
        wb_rd = cand[$urandom_range(0, cand.size() - 1)];
      else
        wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      #1;
      op    = ref_op(instr);
      rtype = (instr[6:0] == 7'h33);
      hz    = (op >= 0) && (m_busy(instr[19:15]) || (rtype && m_busy(instr[24:20])) ||
                            m_busy(instr[11:7]));
      er    = (!m_ov || out_ready) && !hz;
      chk("rnd in_ready", in_ready, er);
      chk("rnd out_valid", out_valid, m_ov);
      if (m_ov) begin
        chk("rnd a", a, m_a);
        chk("rnd b", b, m_b);
        chk("rnd ctl", alu_control, m_ctl);
        chk("rnd rd", rd, m_rd);
        chk("rnd illegal", illegal, m_ill);
      end
      acc = in_valid && er;
      if (acc) begin
        m_ov = 1;
        if (op < 0) begin
          m_ill = 1; m_a = '0; m_b = '0; m_ctl = '0; m_rd = '0;
        end else begin
          m_ill = 0;
          m_a   = m_read(instr[19:15]);
          m_b   = rtype ? m_read(instr[24:20]) : {{20{instr[31]}}, instr[31:20]};
          m_ctl = 3'(op);
          m_rd  = instr[11:7];
        end
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (wb_en && wb_rd != 0) begin
        m_reg[wb_rd]  = wb_data;
        m_pend[wb_rd] = 0;
      end
      if (acc && op >= 0 && instr[11:7] != 0) m_pend[instr[11:7]] = 1;
      stall_prev = in_valid && !er;
      @(posedge clk); #1;
    end

    n = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
